// File: rtl/pipelined_rv32i.sv
// Five-stage in-order RV32I core with ROM, data RAM and memory-mapped I/O; RAW hazards interlock, branches resolve in EX.
// Optional PIPELINED_WB_BYPASS_EN makes the register file write-through so the WB stage need not stall ID.
module pipelined_rv32i #(
  parameter int IMEM_WORDS = 2048,
  parameter int DMEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_lcd,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic        o_ctrl,
  output logic        o_mispred,
  output logic [31:0] o_pc_debug,
  output logic        o_insn_vld
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [31:0] A_LEDR = 32'h1000_0000;
  localparam logic [31:0] A_LEDG = 32'h1000_1000;
  localparam logic [31:0] A_HEXL = 32'h1000_2000;
  localparam logic [31:0] A_HEXH = 32'h1000_3000;
  localparam logic [31:0] A_LCD  = 32'h1000_4000;
  localparam logic [31:0] A_SW   = 32'h1001_0000;

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG: uses_rs1 = 1'b1;
      default: uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    uses_rs2 = (op == OP_BR) || (op == OP_ST) || (op == OP_REG);
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic [31:0] imem [IMEM_WORDS];
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'h0000_0013;
  end

  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf [32];

  logic [31:0] pc;
  logic        if_id_vld;
  logic [31:0] if_id_pc, if_id_insn;
  logic        id_ex_vld;
  logic [31:0] id_ex_pc, id_ex_insn, id_ex_rs1, id_ex_rs2;
  logic        ex_mem_vld, ex_mem_we, ex_mem_ld, ex_mem_st, ex_mem_ctrl, ex_mem_mis;
  logic [31:0] ex_mem_pc, ex_mem_res, ex_mem_rs2;
  logic [4:0]  ex_mem_rd;
  logic [2:0]  ex_mem_f3;
  logic        mem_wb_vld, mem_wb_we, mem_wb_ctrl, mem_wb_mis;
  logic [31:0] mem_wb_pc, mem_wb_dat;
  logic [4:0]  mem_wb_rd;
  logic [31:0] ledr, ledg, hex_lo, hex_hi, lcd;

  // ---------------- IF / ID ----------------
  logic [31:0] if_insn;
  assign if_insn = imem[pc[IAW+1:2]];

  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_we, stall;
  logic [31:0] id_rs1_val, id_rs2_val;
  assign id_op  = if_id_insn[6:0];
  assign id_rs1 = if_id_insn[19:15];
  assign id_rs2 = if_id_insn[24:20];
  assign ex_rd  = id_ex_insn[11:7];
  assign ex_we  = id_ex_vld && writes_rd(id_ex_insn[6:0]);

  function automatic logic hit(input logic [4:0] r);
    hit = (r != 5'd0) && ((ex_we && ex_rd == r) || (ex_mem_we && ex_mem_rd == r)
`ifndef PIPELINED_WB_BYPASS_EN
          || (mem_wb_we && mem_wb_rd == r)
`endif
          );
  endfunction

  assign stall = if_id_vld && ((uses_rs1(id_op) && hit(id_rs1)) || (uses_rs2(id_op) && hit(id_rs2)));

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) rf_read = 32'd0;
`ifdef PIPELINED_WB_BYPASS_EN
    else if (mem_wb_we && mem_wb_rd == r) rf_read = mem_wb_dat;
`endif
    else rf_read = rf[r];
  endfunction

  assign id_rs1_val = rf_read(id_rs1);
  assign id_rs2_val = rf_read(id_rs2);

  // ---------------- EX ----------------
  logic [6:0]  ex_op;
  logic [2:0]  ex_f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] ex_res, ex_target;
  logic        ex_taken, ex_ctrl, redirect;
  assign ex_op = id_ex_insn[6:0];
  assign ex_f3 = id_ex_insn[14:12];
  assign imm_i = {{20{id_ex_insn[31]}}, id_ex_insn[31:20]};
  assign imm_s = {{20{id_ex_insn[31]}}, id_ex_insn[31:25], id_ex_insn[11:7]};
  assign imm_b = {{19{id_ex_insn[31]}}, id_ex_insn[31], id_ex_insn[7], id_ex_insn[30:25], id_ex_insn[11:8], 1'b0};
  assign imm_u = {id_ex_insn[31:12], 12'd0};
  assign imm_j = {{11{id_ex_insn[31]}}, id_ex_insn[31], id_ex_insn[19:12], id_ex_insn[20], id_ex_insn[30:21], 1'b0};

  always_comb begin
    ex_res    = 32'd0;
    ex_target = id_ex_pc + imm_b;
    ex_taken  = 1'b0;
    ex_ctrl   = 1'b0;
    case (ex_op)
      OP_REG:   ex_res = alu(id_ex_rs1, id_ex_rs2, ex_f3, id_ex_insn[30]);
      OP_IMM:   ex_res = alu(id_ex_rs1, imm_i, ex_f3, (ex_f3 == 3'b101) && id_ex_insn[30]);
      OP_LUI:   ex_res = imm_u;
      OP_AUIPC: ex_res = id_ex_pc + imm_u;
      OP_LD:    ex_res = id_ex_rs1 + imm_i;
      OP_ST:    ex_res = id_ex_rs1 + imm_s;
      OP_JAL: begin
        ex_res = id_ex_pc + 32'd4; ex_target = id_ex_pc + imm_j; ex_taken = 1'b1; ex_ctrl = 1'b1;
      end
      OP_JALR: begin
        ex_res = id_ex_pc + 32'd4; ex_target = (id_ex_rs1 + imm_i) & ~32'd1; ex_taken = 1'b1; ex_ctrl = 1'b1;
      end
      OP_BR: begin
        ex_ctrl = 1'b1;
        case (ex_f3)
          3'b000:  ex_taken = id_ex_rs1 == id_ex_rs2;
          3'b001:  ex_taken = id_ex_rs1 != id_ex_rs2;
          3'b100:  ex_taken = $signed(id_ex_rs1) <  $signed(id_ex_rs2);
          3'b101:  ex_taken = $signed(id_ex_rs1) >= $signed(id_ex_rs2);
          3'b110:  ex_taken = id_ex_rs1 <  id_ex_rs2;
          3'b111:  ex_taken = id_ex_rs1 >= id_ex_rs2;
          default: ex_taken = 1'b0;
        endcase
      end
      default: ex_res = 32'd0;  // FENCE/SYSTEM/illegal retire as NOP
    endcase
  end
  assign redirect = id_ex_vld && ex_taken;

  // ---------------- MEM ----------------
  logic [31:0] maddr, mword, rdata, shifted, ld_dat, wdat, wbits;
  logic [3:0]  wmask;
  logic        ram_sel;
  assign maddr   = ex_mem_res;
  assign mword   = {maddr[31:2], 2'b00};
  assign ram_sel = maddr[31:DAW+2] == '0;

  always_comb begin
    rdata = 32'd0;
    if (ram_sel) rdata = dmem[maddr[DAW+1:2]];
    else begin
      case (mword)
        A_LEDR:  rdata = ledr;
        A_LEDG:  rdata = ledg;
        A_HEXL:  rdata = hex_lo;
        A_HEXH:  rdata = hex_hi;
        A_LCD:   rdata = lcd;
        A_SW:    rdata = i_io_sw;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign shifted = rdata >> {maddr[1:0], 3'b000};
  always_comb begin
    case (ex_mem_f3)
      3'b000:  ld_dat = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_dat = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_dat = {24'd0, shifted[7:0]};
      3'b101:  ld_dat = {16'd0, shifted[15:0]};
      default: ld_dat = rdata;
    endcase
  end

  always_comb begin
    case (ex_mem_f3[1:0])
      2'b00:   begin wdat = {4{ex_mem_rs2[7:0]}};  wmask = 4'b0001 << maddr[1:0]; end
      2'b01:   begin wdat = {2{ex_mem_rs2[15:0]}}; wmask = maddr[1] ? 4'b1100 : 4'b0011; end
      default: begin wdat = ex_mem_rs2;            wmask = 4'b1111; end
    endcase
  end
  assign wbits = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv, input logic [31:0] m);
    merge = (old & ~m) | (nv & m);
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_reset && ex_mem_st && ram_sel)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) dmem[maddr[DAW+1:2]][8*b +: 8] <= wdat[8*b +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr <= '0; ledg <= '0; hex_lo <= '0; hex_hi <= '0; lcd <= '0;
    end else if (ex_mem_st && !ram_sel) begin
      if (mword == A_LEDR) ledr   <= merge(ledr,   wdat, wbits);
      if (mword == A_LEDG) ledg   <= merge(ledg,   wdat, wbits);
      if (mword == A_HEXL) hex_lo <= merge(hex_lo, wdat, wbits);
      if (mword == A_HEXH) hex_hi <= merge(hex_hi, wdat, wbits);
      if (mword == A_LCD)  lcd    <= merge(lcd,    wdat, wbits);
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc <= '0;
      if_id_vld <= 1'b0; if_id_pc <= '0; if_id_insn <= '0;
      id_ex_vld <= 1'b0; id_ex_pc <= '0; id_ex_insn <= '0; id_ex_rs1 <= '0; id_ex_rs2 <= '0;
      ex_mem_vld <= 1'b0; ex_mem_we <= 1'b0; ex_mem_ld <= 1'b0; ex_mem_st <= 1'b0;
      ex_mem_ctrl <= 1'b0; ex_mem_mis <= 1'b0; ex_mem_pc <= '0; ex_mem_res <= '0;
      ex_mem_rs2 <= '0; ex_mem_rd <= '0; ex_mem_f3 <= '0;
      mem_wb_vld <= 1'b0; mem_wb_we <= 1'b0; mem_wb_ctrl <= 1'b0; mem_wb_mis <= 1'b0;
      mem_wb_pc <= '0; mem_wb_dat <= '0; mem_wb_rd <= '0;
    end else begin
      if (redirect)    pc <= ex_target;
      else if (!stall) pc <= pc + 32'd4;

      if (redirect) if_id_vld <= 1'b0;
      else if (!stall) begin
        if_id_vld <= 1'b1; if_id_pc <= pc; if_id_insn <= if_insn;
      end

      // redirect outranks stall: the ID slot is squashed either way
      id_ex_vld  <= if_id_vld && !stall && !redirect;
      id_ex_pc   <= if_id_pc;
      id_ex_insn <= if_id_insn;
      id_ex_rs1  <= id_rs1_val;
      id_ex_rs2  <= id_rs2_val;

      ex_mem_vld  <= id_ex_vld;
      ex_mem_we   <= ex_we;
      ex_mem_ld   <= id_ex_vld && ex_op == OP_LD;
      ex_mem_st   <= id_ex_vld && ex_op == OP_ST;
      ex_mem_ctrl <= id_ex_vld && ex_ctrl;
      ex_mem_mis  <= redirect;
      ex_mem_pc   <= id_ex_pc;
      ex_mem_res  <= ex_res;
      ex_mem_rs2  <= id_ex_rs2;
      ex_mem_rd   <= ex_rd;
      ex_mem_f3   <= ex_f3;

      mem_wb_vld  <= ex_mem_vld;
      mem_wb_we   <= ex_mem_we;
      mem_wb_ctrl <= ex_mem_ctrl;
      mem_wb_mis  <= ex_mem_mis;
      mem_wb_pc   <= ex_mem_vld ? ex_mem_pc : 32'd0;
      mem_wb_dat  <= ex_mem_ld ? ld_dat : ex_mem_res;
      mem_wb_rd   <= ex_mem_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < 32; r++) rf[r] <= '0;
    end else if (mem_wb_we && mem_wb_rd != 5'd0) begin
      rf[mem_wb_rd] <= mem_wb_dat;
    end
  end

  assign o_insn_vld = mem_wb_vld;
  assign o_pc_debug = mem_wb_pc;
  assign o_ctrl     = mem_wb_ctrl;
  assign o_mispred  = mem_wb_mis;
  assign o_io_ledr  = ledr;
  assign o_io_ledg  = ledg;
  assign o_io_lcd   = lcd;
  assign o_io_hex0  = hex_lo[6:0];
  assign o_io_hex1  = hex_lo[14:8];
  assign o_io_hex2  = hex_lo[22:16];
  assign o_io_hex3  = hex_lo[30:24];
  assign o_io_hex4  = hex_hi[6:0];
  assign o_io_hex5  = hex_hi[14:8];
  assign o_io_hex6  = hex_hi[22:16];
  assign o_io_hex7  = hex_hi[30:24];
endmodule

// File: tb/tb_pipelined_rv32i.sv
// Directed programs for pipelined_rv32i: reset, RAW interlock, switch/RAM loads, branches, byte stores, x0.
module tb_pipelined_rv32i;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_io_sw;
  logic [31:0] o_io_lcd, o_io_ledr, o_io_ledg, o_pc_debug;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
  logic        o_ctrl, o_mispred, o_insn_vld;

  pipelined_rv32i dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_io_sw(i_io_sw),
    .o_io_lcd(o_io_lcd), .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
    .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2), .o_io_hex3(o_io_hex3),
    .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5), .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7),
    .o_ctrl(o_ctrl), .o_mispred(o_mispred), .o_pc_debug(o_pc_debug), .o_insn_vld(o_insn_vld)
  );

  always #5 i_clk = ~i_clk;

`ifdef PIPELINED_WB_BYPASS_EN
  localparam int RAW_BUBBLES = 2;
`else
  localparam int RAW_BUBBLES = 3;
`endif

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [31:0] prog [$];
  logic [31:0] ret_pc [$];
  int          ret_cyc [$];
  logic        ret_ctrl [$];
  logic        ret_mis [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 2048; i++) dut.imem[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
  endtask

  task automatic restart();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    load_prog();
    ret_pc.delete(); ret_cyc.delete(); ret_ctrl.delete(); ret_mis.delete();
    cyc = 0;
    i_reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_insn_vld) begin
        ret_pc.push_back(o_pc_debug); ret_cyc.push_back(cyc);
        ret_ctrl.push_back(o_ctrl);   ret_mis.push_back(o_mispred);
      end
    end
  endtask

  function automatic int find_ret(input logic [31:0] p);
    for (int i = 0; i < ret_pc.size(); i++) if (ret_pc[i] == p) return i;
    return -1;
  endfunction

  initial begin
    int k, j;
    i_reset = 1'b1;
    i_io_sw = 32'd0;
    #1;
    // RAW program: addi x1,x0,5; addi x2,x1,3; lui x5,0x10000; sw x2,0(x5)
    prog = '{32'h0050_0093, 32'h0030_8113, 32'h1000_02B7, 32'h0022_A023};
    load_prog();
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      chk("rst_insn_vld", 32'(o_insn_vld), 32'd0);
    end
    chk("rst_pc_debug", o_pc_debug, 32'd0);
    chk("rst_ctrl_mispred", {30'd0, o_ctrl, o_mispred}, 32'd0);
    chk("rst_ledr", o_io_ledr, 32'd0);
    chk("rst_hex", {4'd0, o_io_hex3, o_io_hex2, o_io_hex1, o_io_hex0}, 32'd0);
    ret_pc.delete(); ret_cyc.delete(); ret_ctrl.delete(); ret_mis.delete();
    cyc = 0;
    i_reset = 1'b0;
    run(40);
    chk("first_retire_cycle", 32'(ret_cyc.size() > 0 ? ret_cyc[0] : -1), 32'd4);
    chk("first_retire_pc", ret_pc.size() > 0 ? ret_pc[0] : 32'hFFFF_FFFF, 32'd0);
    k = find_ret(32'd0); j = find_ret(32'd4);
    chk("raw_bubbles", 32'((k >= 0 && j >= 0) ? ret_cyc[j] - ret_cyc[k] - 1 : -1), 32'(RAW_BUBBLES));
    chk("raw_ledr", o_io_ledr, 32'd8);

    // Switch read, RAM round trip: lw sw -> LEDG, sw/lw at 16 -> LCD
    prog = '{32'h1001_02B7, 32'h0002_A303, 32'h1000_13B7, 32'h0063_A023,
             32'h0060_2823, 32'h0100_2403, 32'h1000_44B7, 32'h0084_A023};
    i_io_sw = 32'h0000_00A5;
    restart();
    chk("reset_clears_ledr", o_io_ledr, 32'd0);
    chk("reset_clears_vld", 32'(o_insn_vld), 32'd0);
    run(60);
    chk("sw_to_ledg", o_io_ledg, 32'h0000_00A5);
    chk("ram_roundtrip_lcd", o_io_lcd, 32'h0000_00A5);

    // Taken branch: lui x5; addi x1,x0,1; beq x0,x0,+12; addi x1,x0,7; sw x1; sw x1
    prog = '{32'h1000_02B7, 32'h0010_0093, 32'h0000_0663, 32'h0070_0093,
             32'h0012_A023, 32'h0012_A023};
    restart();
    run(50);
    k = find_ret(32'd8);
    chk("beq_found", 32'(k >= 0), 32'd1);
    chk("beq_ctrl", (k >= 0) ? 32'(ret_ctrl[k]) : 32'hX, 32'd1);
    chk("beq_mispred", (k >= 0) ? 32'(ret_mis[k]) : 32'hX, 32'd1);
    chk("beq_next_pc", (k >= 0 && k + 1 < ret_pc.size()) ? ret_pc[k+1] : 32'hX, 32'd20);
    j = find_ret(32'd4);
    chk("addi_not_ctrl", (j >= 0) ? 32'(ret_ctrl[j]) : 32'hX, 32'd0);
    chk("beq_skip_ledr", o_io_ledr, 32'd1);

    // Not-taken branch: same program with bne x0,x0,+12
    prog[2] = 32'h0000_1663;
    restart();
    run(50);
    k = find_ret(32'd8);
    chk("bne_ctrl", (k >= 0) ? 32'(ret_ctrl[k]) : 32'hX, 32'd1);
    chk("bne_mispred", (k >= 0) ? 32'(ret_mis[k]) : 32'hX, 32'd0);
    chk("bne_next_pc", (k >= 0 && k + 1 < ret_pc.size()) ? ret_pc[k+1] : 32'hX, 32'd12);
    chk("bne_ledr", o_io_ledr, 32'd7);

    // Byte store into HEX0-3, lbu read-back to LCD, x0 write ignored
    prog = '{32'h1000_22B7, 32'h1234_50B7, 32'h6780_8093, 32'h0012_A023,
             32'h03F0_0113, 32'h0022_80A3, 32'h1000_4337, 32'h0012_C183,
             32'h0033_2023, 32'h1000_03B7, 32'h0013_A023, 32'h0050_0013,
             32'h0003_A023};
    restart();
    run(90);
    chk("sb_hex0", 32'(o_io_hex0), 32'h78);
    chk("sb_hex1", 32'(o_io_hex1), 32'h3F);
    chk("sb_hex2", 32'(o_io_hex2), 32'h34);
    chk("sb_hex3", 32'(o_io_hex3), 32'h12);
    chk("hex4_7_idle", {4'd0, o_io_hex7, o_io_hex6, o_io_hex5, o_io_hex4}, 32'd0);
    chk("lbu_readback_lcd", o_io_lcd, 32'h0000_003F);
    chk("x0_hardwired_ledr", o_io_ledr, 32'd0);
    chk("final_retire_seen", 32'(find_ret(32'd48) >= 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
